// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM states and counter sizing.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_div_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
interface seq_restoring_div_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_div_cla_sub.sv
// Combinational N-bit subtractor a - b = a + ~b + 1 with flat carry-lookahead.
module cla_sub #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);
    logic [N-1:0] bn;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign bn = ~b;
    assign g  = a & bn;
    assign p  = a ^ bn;

    // Each carry is an OR of generate terms gated by the propagate chain above them.
    always_comb begin
        logic run;
        c    = '0;
        c[0] = 1'b1;
        run  = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            run      = 1'b1;
            c[i+1]   = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run & g[j]);
                run    = run & p[j];
            end
            c[i+1] = c[i+1] | (run & c[0]);
        end
    end

    assign diff       = p ^ c[N-1:0];
    assign borrow_out = ~c[N];
endmodule

// File: rtl/seq_restoring_div.sv
// Iterative unsigned restoring divider: one trial subtraction per clock, start/done handshake.
module seq_restoring_div
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    seq_restoring_div_if.slave  io
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned RW    = WIDTH + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [RW-1:0]    r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [RW-1:0]    diff;
    logic             borrow;

    // {R,Q} shifted left by one; the partial remainder never needs its top bit here.
    assign r_shift = RW'({r_q, q_q[WIDTH-1]});
    assign q_shift = {q_q[WIDTH-2:0], 1'b0};

    cla_sub #(.N(RW)) u_sub (
        .a          (r_shift),
        .b          ({1'b0, d_q}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    if (io.divisor == '0) begin
                        quo_d  = '1;
                        rem_d  = io.dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        q_d     = io.dividend;
                        r_d     = '0;
                        d_d     = io.divisor;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (borrow) begin
                    r_d = r_shift;
                    q_d = q_shift;
                end else begin
                    r_d = diff;
                    q_d = q_shift | WIDTH'(1);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quo_d   = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
        end else begin
            q_q    <= q_d;
            d_q    <= d_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
        end
    end

    assign io.busy        = busy_q;
    assign io.done        = done_q;
    assign io.quotient    = quo_q;
    assign io.remainder   = rem_q;
    assign io.div_by_zero = dbz_q;
endmodule
